iterative_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier for the ALU datapath: one partial product per clock through a single WIDTH-bit adder instead of a full combinational array. Supports unsigned and two's-complement signed operands, selected per operation. Uses a start/busy/done handshake so the ALU control FSM can issue an operation and collect the product WIDTH+1 clocks later.

---
 rtl/iterative_multiplier_pkg.sv | 19 +
 rtl/iterative_multiplier_adder.sv | 25 ++
 rtl/iterative_multiplier.sv | 133 +++++++++++++
 tb/tb_iterative_multiplier.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/iterative_multiplier_pkg.sv
// Shared ALU definitions for the iterative shift-add multiplier:
// FSM state type, default operand width and counter sizing helper.
package iterative_multiplier_pkg;

   // Two-bit state code; the fourth code is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      SIGN = 2'b10
   } state_t;

   localparam int MUL_WIDTH_DEFAULT = 16;

   // Iteration counter must be able to hold WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/iterative_multiplier_adder.sv
// Parametrised ripple-carry adder with carry-in and carry-out, used
// once per RUN cycle to fold the multiplicand into the accumulator.
module n_bit_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   // Bitwise ripple of the carry from LSB to MSB.
   always_comb begin
      carry[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      cout = carry[WIDTH];
   end

endmodule

// File: rtl/iterative_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock through a
// single WIDTH-bit adder. Signed operands are reduced to magnitudes up front
// and the sign is reapplied in a final SIGN cycle, so the datapath itself is
// purely unsigned. Result arrives WIDTH+1 clocks after an accepted start.
module iterative_multiplier
   import iterative_multiplier_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_P    = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   state_t               state_q, state_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     mag_a_q, mag_a_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH-1:0]     add_b, add_sum;
   logic                 add_cout;
   logic [2*WIDTH-1:0]   acc, acc_neg;

   // The multiplicand only enters the sum when the current multiplier bit is set.
   assign add_b = lo_q[0] ? mag_a_q : '0;

   n_bit_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (hi_q),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Operand magnitudes and the signed result of the finished accumulator.
   always_comb begin
      a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
      b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;
      acc     = {hi_q, lo_q};
      acc_neg = ~acc + ONE_P;
   end

   // Next-state and datapath update for the IDLE -> RUN -> SIGN sequence.
   always_comb begin
      state_d   = state_q;
      neg_d     = neg_q;
      mag_a_d   = mag_a_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               mag_a_d = a_mag;
               hi_d    = '0;
               lo_d    = b_mag;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Shift {carry, sum, lo} right by one: the consumed multiplier bit
            // drops off lo while the settled product bit moves in from the top.
            hi_d  = {add_cout, add_sum[WIDTH-1:1]};
            lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            // Negating a zero accumulator yields zero, so no -0 can appear.
            product_d = neg_q ? acc_neg : acc;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         neg_q     <= 1'b0;
         mag_a_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         neg_q     <= neg_d;
         mag_a_q   <= mag_a_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == RUN) || (state_q == SIGN);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench for iterative_multiplier: directed corners plus
// randomised operands against an integer-arithmetic reference model.
module tb_iterative_multiplier;

   localparam int W  = 16;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          signed_mode = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy;
   logic          done;
   logic [PW-1:0] product;

   int n_checks = 0;
   int n_errors = 0;

   iterative_multiplier #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .product     (product)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer multiply of the operands as numbers, truncated to 2*W.
   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
      longint xs, ys;
      if (s) begin
         xs = longint'($signed(x));
         ys = longint'($signed(y));
      end else begin
         xs = longint'(x);
         ys = longint'(y);
      end
      return PW'(xs * ys);
   endfunction

   // Issue one operation and wait (bounded) for done. When poke is set, start is
   // re-asserted and operands scrambled mid-flight.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input bit poke, output logic [PW-1:0] p, output int lat);
      logic [PW-1:0] prev;
      bit got, busy_ok, held_ok;
      @(negedge clk);
      a = av; b = bv; signed_mode = sv; start = 1'b1;
      prev = product;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("busy_after_start", 64'(busy), 64'd1);
      check_eq("done_single_pulse", 64'(done), 64'd0);
      lat = 0; got = 0; busy_ok = 1; held_ok = 1;
      while (!got && lat < 4 * W) begin
         if (poke) begin
            start       = (lat == 3 || lat == 10);
            a           = W'($urandom);
            b           = W'($urandom);
            signed_mode = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
         if (done) got = 1;
         else begin
            if (busy !== 1'b1) busy_ok = 0;
            if (product !== prev) held_ok = 0;
         end
      end
      start = 1'b0;
      check_eq("busy_in_done_cycle", 64'(busy), 64'd0);
      check_eq("busy_unbroken", 64'(busy_ok), 64'd1);
      check_eq("product_held", 64'(held_ok), 64'd1);
      p = product;
   endtask

   logic [PW-1:0] p;
   int            lat;
   bit            seen_done;
   logic [W-1:0]  ra, rb;

   initial begin
      // Asynchronous reset state, observed before any clock edge.
      #2;
      check_eq("reset_busy", 64'(busy), 64'd0);
      check_eq("reset_done", 64'(done), 64'd0);
      check_eq("reset_product", 64'(product), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Unsigned maximum.
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, p, lat);
      check_eq("umax_product", 64'(p), 64'hFFFE0001);
      check_eq("umax_latency", 64'(lat), 64'(W + 1));

      // Signed corners.
      run_op(16'h8000, 16'h8000, 1'b1, 0, p, lat);
      check_eq("s_min_min", 64'(p), 64'h40000000);
      run_op(16'h8000, 16'h0001, 1'b1, 0, p, lat);
      check_eq("s_min_one", 64'(p), 64'hFFFF8000);
      run_op(16'hFFFF, 16'h0007, 1'b1, 0, p, lat);
      check_eq("s_neg1_7", 64'(p), 64'hFFFFFFF9);
      run_op(16'h0000, 16'h8000, 1'b1, 0, p, lat);
      check_eq("s_zero_min", 64'(p), 64'h00000000);
      check_eq("zero_latency", 64'(lat), 64'(W + 1));

      // Start while busy ignored; operands scrambled mid-flight.
      run_op(16'h0003, 16'h0005, 1'b0, 1, p, lat);
      check_eq("ignored_start_product", 64'(p), 64'h0000000F);
      check_eq("ignored_start_latency", 64'(lat), 64'(W + 1));
      // No second done from the ignored starts.
      seen_done = 0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (done) seen_done = 1;
      end
      check_eq("ignored_start_no_extra_done", 64'(seen_done), 64'd0);

      // Back-to-back: the next run_op asserts start in the done cycle.
      run_op(16'h00FF, 16'h0101, 1'b0, 0, p, lat);
      check_eq("b2b_first", 64'(p), 64'h0000FFFF);
      run_op(16'h1234, 16'h0010, 1'b0, 0, p, lat);
      check_eq("b2b_second", 64'(p), 64'h00012340);
      check_eq("b2b_latency", 64'(lat), 64'(W + 1));

      // Reset mid-operation.
      @(negedge clk);
      a = 16'h0123; b = 16'h0456; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_eq("pre_reset_busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_done", 64'(done), 64'd0);
      check_eq("abort_product", 64'(product), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (done) seen_done = 1;
      end
      check_eq("abort_no_done", 64'(seen_done), 64'd0);
      run_op(16'h0123, 16'h0456, 1'b0, 0, p, lat);
      check_eq("after_abort_product", 64'(p), 64'(ref_mul(16'h0123, 16'h0456, 1'b0)));
      check_eq("after_abort_latency", 64'(lat), 64'(W + 1));

      // Randomised operands in both modes, with periodic extreme values.
      for (int mode = 0; mode < 2; mode++) begin
         for (int i = 0; i < 1500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 16 == 0) ra = (i % 32 == 0) ? {1'b1, {(W-1){1'b0}}} : '1;
            if (i % 24 == 0) rb = (i % 48 == 0) ? '0 : {1'b0, {(W-1){1'b1}}};
            run_op(ra, rb, 1'(mode), 0, p, lat);
            check_eq(mode == 1 ? "rand_signed" : "rand_unsigned", 64'(p),
                     64'(ref_mul(ra, rb, 1'(mode))));
            check_eq("rand_latency", 64'(lat), 64'(W + 1));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
